// File: rtl/fifo_wr_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_packer
// Description : Write-side front end for the asynchronous FIFO (write clock
//               domain only). Packs RATIO narrow input beats into one
//               FIFO-width word, LSB lane first, and feeds the FIFO through a
//               one-word hold register that honours the registered full flag.
//               in_last closes a word early; unfilled lanes are zero.
// Ports       : myWclk, myWrst_n      - write clock / async active-low reset
//               in_valid, in_ready,
//               in_data, in_last      - narrow input stream
//               myWfull               - FIFO full flag (registered)
//               myWreq, myWdata       - FIFO write request / data
//               busy                  - partial word or held word present
//               stat_words, stat_stall- statistics (FIFO_WR_PACKER_STATS_EN)
// Options     : define FIFO_WR_PACKER_STATS_EN to add the statistics counters
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_packer #(
    parameter int IN_W   = 2,
    parameter int RATIO  = 4,
    parameter int DATA_W = IN_W * RATIO
`ifdef FIFO_WR_PACKER_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              myWclk,
    input  logic              myWrst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_last,
    input  logic              myWfull,
    output logic              myWreq,
    output logic [DATA_W-1:0] myWdata,
    output logic              busy
`ifdef FIFO_WR_PACKER_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_words,
    output logic [CNT_W-1:0]  stat_stall
`endif
);

    localparam int              c_lane_w    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam [c_lane_w-1:0]   c_last_lane = c_lane_w'(RATIO - 1);

    logic [DATA_W-1:0]   r_acc;
    logic [c_lane_w-1:0] r_lane;
    logic                r_hold_valid;
    logic [DATA_W-1:0]   r_hold_data;

    logic                w_drain;
    logic                w_accept;
    logic                w_close;
    logic [DATA_W-1:0]   w_insert;
    logic [DATA_W-1:0]   w_word;

    // The current beat placed in its lane, all other lanes zero.
    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        assign w_insert[k*IN_W +: IN_W] = (r_lane == c_lane_w'(k)) ? in_data : '0;
    end

    // Lanes above the current one are always zero in the accumulator (it is
    // cleared on every close and filled strictly upwards), so OR-ing in the
    // current beat already yields the zero-padded word.
    assign w_word   = r_acc | w_insert;

    assign w_drain  = r_hold_valid & ~myWfull;
    // The hold register frees in the same cycle it drains, so a full FIFO
    // with nothing held never blocks the input.
    assign in_ready = ~r_hold_valid | ~myWfull;
    assign w_accept = in_valid & in_ready;
    assign w_close  = (r_lane == c_last_lane) | in_last;

    assign myWreq   = w_drain;
    assign myWdata  = r_hold_data;
    assign busy     = (r_lane != '0) | r_hold_valid;

    always_ff @(posedge myWclk or negedge myWrst_n) begin
        if (!myWrst_n) begin
            r_acc        <= '0;
            r_lane       <= '0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else begin
            if (w_accept && w_close) begin
                // Load wins over drain: a same-cycle drain and load keeps
                // hold_valid set and replaces the data.
                r_hold_data  <= w_word;
                r_hold_valid <= 1'b1;
                r_acc        <= '0;
                r_lane       <= '0;
            end else begin
                if (w_drain) begin
                    r_hold_valid <= 1'b0;
                end
                if (w_accept) begin
                    r_acc  <= w_word;
                    r_lane <= r_lane + c_lane_w'(1);
                end
            end
        end
    end

`ifdef FIFO_WR_PACKER_STATS_EN
    logic [CNT_W-1:0] r_stat_words;
    logic [CNT_W-1:0] r_stat_stall;

    always_ff @(posedge myWclk or negedge myWrst_n) begin
        if (!myWrst_n) begin
            r_stat_words <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_drain) begin
                r_stat_words <= r_stat_words + CNT_W'(1);
            end
            if (r_hold_valid && myWfull) begin
                r_stat_stall <= r_stat_stall + CNT_W'(1);
            end
        end
    end

    assign stat_words = r_stat_words;
    assign stat_stall = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_packer
// Description : Self-checking bench for fifo_wr_packer. A word-level model
//               (beat count, running word, one held word) predicts every
//               output each cycle; directed sequences pin literal words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_packer;

    localparam int IN_W   = 2;
    localparam int RATIO  = 4;
    localparam int DATA_W = IN_W * RATIO;

    logic              myWclk = 1'b0;
    logic              myWrst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IN_W-1:0]   in_data = '0;
    logic              in_last = 1'b0;
    logic              myWfull = 1'b0;
    logic              myWreq;
    logic [DATA_W-1:0] myWdata;
    logic              busy;
`ifdef FIFO_WR_PACKER_STATS_EN
    logic [15:0]       stat_words;
    logic [15:0]       stat_stall;
`endif

    fifo_wr_packer dut (
        .myWclk   (myWclk),
        .myWrst_n (myWrst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .myWfull  (myWfull),
        .myWreq   (myWreq),
        .myWdata  (myWdata),
        .busy     (busy)
`ifdef FIFO_WR_PACKER_STATS_EN
        ,
        .stat_words (stat_words),
        .stat_stall (stat_stall)
`endif
    );

    always #5 myWclk = ~myWclk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: number of beats collected so far, the word built
    // from them arithmetically, and the single held word.
    int          m_cnt;
    int unsigned m_word;
    bit          m_hv;
    int unsigned m_hold;
    int unsigned m_words;
    int unsigned m_stall;

    // Observations from the most recent step, for literal checks.
    bit          last_req;
    bit          last_ready;
    int unsigned last_data;
    int          req_count;
    bit          ready_dropped;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_word = 0; m_hv = 0; m_hold = 0; m_words = 0; m_stall = 0;
    endtask

    // One clock cycle: drive inputs, compare every output to the model,
    // then advance the model by the rules for the coming edge.
    task automatic step(input bit v, input int d, input bit l, input bit f);
        bit exp_ready, exp_req, take;
        @(negedge myWclk);
        in_valid = v;
        in_data  = IN_W'(d);
        in_last  = l;
        myWfull  = f;
        #1;
        exp_ready = !m_hv || !f;
        exp_req   = m_hv && !f;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("myWreq",   32'(myWreq),   32'(exp_req));
        check("myWdata",  32'(myWdata),  m_hold);
        check("busy",     32'(busy),     32'((m_cnt != 0) || m_hv));
`ifdef FIFO_WR_PACKER_STATS_EN
        check("stat_words", 32'(stat_words), m_words & 32'hFFFF);
        check("stat_stall", 32'(stat_stall), m_stall & 32'hFFFF);
`endif
        last_req   = myWreq;
        last_ready = in_ready;
        last_data  = 32'(myWdata);
        if (myWreq) req_count++;
        if (!in_ready) ready_dropped = 1;

        if (exp_req) m_words++;
        if (m_hv && f) m_stall++;
        take = v && exp_ready;
        if (exp_req) m_hv = 0;
        if (take) begin
            m_word = m_word | (int'(d) << (IN_W * m_cnt));
            m_cnt++;
            if (m_cnt == RATIO || l) begin
                m_hold = m_word & ((1 << DATA_W) - 1);
                m_hv   = 1;
                m_word = 0;
                m_cnt  = 0;
            end
        end
        @(posedge myWclk);
    endtask

    task automatic pulse_reset();
        @(negedge myWclk);
        myWrst_n = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        myWfull  = 1'b0;
        model_reset();
        #1;
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_req",   32'(myWreq),   32'd0);
        check("rst_data",  32'(myWdata),  32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        @(negedge myWclk);
        myWrst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        req_count = 0;
        ready_dropped = 0;
        last_req = 0; last_ready = 0; last_data = 0;
        repeat (3) @(posedge myWclk);
        pulse_reset();

        // Full word: 0,1,2,3 -> E4 one cycle after the fourth beat.
        for (int i = 0; i < 4; i++) step(1, i, 0, 0);
        step(0, 0, 0, 0);
        check("full_req",  32'(last_req), 32'd1);
        check("full_data", last_data,     32'hE4);

        // Short word: 3,1 with last -> 07.
        step(1, 3, 0, 0);
        step(1, 1, 1, 0);
        step(0, 0, 0, 0);
        check("short_data", last_data, 32'h07);

        // Single-beat last at lane 0 -> 02 (also proves lane restarted at 0).
        step(1, 2, 1, 0);
        step(0, 0, 0, 0);
        check("single_req",  32'(last_req), 32'd1);
        check("single_data", last_data,     32'h02);

        // Back-pressure: hold word 01, then full for 5 cycles.
        step(1, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 3, 0, 1);
            check("bp_req",   32'(last_req),   32'd0);
            check("bp_ready", 32'(last_ready), 32'd0);
            check("bp_data",  last_data,       32'h01);
        end
        step(0, 0, 0, 0);
        check("bp_release_req",   32'(last_req),   32'd1);
        check("bp_release_ready", 32'(last_ready), 32'd1);
`ifdef FIFO_WR_PACKER_STATS_EN
        check("bp_stat_stall", 32'(stat_stall), 32'd5);
`endif

        // Streaming: 8 beats back-to-back -> two E4 words, no stall.
        req_count = 0;
        ready_dropped = 0;
        for (int i = 0; i < 8; i++) step(1, i % 4, 0, 0);
        step(0, 0, 0, 0);
        check("stream_words", 32'(req_count),     32'd2);
        check("stream_data",  last_data,          32'hE4);
        check("stream_ready", 32'(ready_dropped), 32'd0);
`ifdef FIFO_WR_PACKER_STATS_EN
        check("stream_stat_words", 32'(stat_words), 32'd6);
`endif

        // Reset mid-word: partial data discarded, next word starts at lane 0.
        step(1, 1, 0, 0);
        step(1, 2, 0, 0);
        pulse_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        check("post_rst_data", last_data, 32'h55);

        // Randomized traffic against the model, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
            end else begin
                step(bit'($urandom_range(0, 3) != 0),
                     int'($urandom_range(0, 3)),
                     bit'($urandom_range(0, 5) == 0),
                     bit'($urandom_range(0, 9) < 3));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
